// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - iterative 32-bit restoring divider for the DIV/DIVU path
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request, sampled only while idle
//   Sign            1 = signed (DIV), 0 = unsigned (DIVU)
//   A, B            dividend, divisor (captured with start)
//   quo, rem        quotient (LO) and remainder (HI), held until next completion
//   busy            high while a division is in flight
//   done            one-cycle completion pulse
//   dz              divide-by-zero flag of the last completed op

module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] pr;       // partial remainder
    logic [WIDTH-1:0] qd;       // dividend bits shift out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0] bmag;
    logic             qneg;
    logic             rneg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Magnitude of the most negative value wraps to itself, which is still
    // correct when read as unsigned, so no extra datapath bit is needed.
    always_comb begin
        a_mag = (Sign && A[WIDTH-1]) ? (~A + 1'b1) : A;
        b_mag = (Sign && B[WIDTH-1]) ? (~B + 1'b1) : B;
    end

    // Partial remainder stays below |B|, so the 33-bit trial result always
    // lies in [-|B|, |B|-1] and its top bit is a valid sign.
    always_comb begin
        shifted = {pr, qd[WIDTH-1]};
        trial   = shifted - {1'b0, bmag};
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && (B != '0)) state_nxt = CALC;
            CALC:    if (cnt == '0)          state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo  <= '0;
            rem  <= '0;
            done <= 1'b0;
            dz   <= 1'b0;
            pr   <= '0;
            qd   <= '0;
            bmag <= '0;
            cnt  <= '0;
            qneg <= 1'b0;
            rneg <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (B == '0) begin
                            // Divide-by-zero completes immediately without entering CALC.
                            quo  <= '1;
                            rem  <= A;
                            dz   <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            qd   <= a_mag;
                            bmag <= b_mag;
                            pr   <= '0;
                            cnt  <= CW'(WIDTH - 1);
                            qneg <= Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                            rneg <= Sign & A[WIDTH-1];
                        end
                    end
                end
                CALC: begin
                    pr  <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    qd  <= {qd[WIDTH-2:0], ~trial[WIDTH]};
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    quo  <= qneg ? (~qd + 1'b1) : qd;
                    rem  <= rneg ? (~pr + 1'b1) : pr;
                    dz   <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_divider.sv
// tb/tb_alu_divider.sv - self-checking bench for alu_divider

module tb_alu_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        Sign;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        busy;
    logic        done;
    logic        dz;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_lq = '0;
    logic [31:0] exp_lr = '0;

    alu_divider #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Sign  (Sign),
        .A     (A),
        .B     (B),
        .quo   (quo),
        .rem   (rem),
        .busy  (busy),
        .done  (done),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; 64-bit signed arithmetic truncates
    // toward zero with the remainder taking the dividend's sign.
    function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Drives one request, then waits for done. Returns just after the done edge
    // so a following call presents its start in the done cycle.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        int          n;
        model(s, a, b, eq, er);
        Sign  = s;
        A     = a;
        B     = b;
        start = 1'b1;
        n     = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                start = 1'b0;
                chk({tag, "_busy_rise"}, 32'(busy), 32'(b != 0));
                if (b != 0) begin
                    chk({tag, "_prev_quo"}, quo, exp_lq);
                    chk({tag, "_prev_rem"}, rem, exp_lr);
                end
            end
            if (inject_at != 0 && i == inject_at) begin
                Sign  = ~s;
                A     = $urandom;
                B     = $urandom | 32'd1;
                start = 1'b1;
            end
            if (inject_at != 0 && i == inject_at + 1) start = 1'b0;
            if (done) begin
                n = i;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, 32'(n), (b == 0) ? 32'd1 : 32'd34);
        chk({tag, "_quo"}, quo, eq);
        chk({tag, "_rem"}, rem, er);
        chk({tag, "_dz"}, 32'(dz), 32'(b == 0));
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
        exp_lq = eq;
        exp_lr = er;
    endtask

    initial begin
        int          cnt_done;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        rst   = 1'b1;
        start = 1'b0;
        Sign  = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_quo", quo, 32'd0);
        chk("rst_rem", rem, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dz", 32'(dz), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(1'b0, 32'd100, 32'd7, 0, "u100_7");
        @(posedge clk);
        #1;
        chk("done_pulse_len", 32'(done), 32'd0);

        run_op(1'b1, 32'hFFFFFFF9, 32'd2, 0, "s_m7_2");
        run_op(1'b1, 32'd7, 32'hFFFFFFFE, 0, "s_7_m2");
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, "s_wrap");
        run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 0, "u_edge");

        run_op(1'b0, 32'h12345678, 32'd0, 0, "dz");
        @(posedge clk);
        #1;
        chk("dz_done_fall", 32'(done), 32'd0);
        chk("dz_busy_low", 32'(busy), 32'd0);
        chk("dz_hold", 32'(dz), 32'd1);

        run_op(1'b0, 32'd1000, 32'd9, 10, "inject");
        run_op(1'b1, 32'hFFFF0000, 32'd3, 0, "b2b");

        // Reset mid-CALC discards the op; start is ignored while rst is high.
        Sign  = 1'b0;
        A     = $urandom;
        B     = 32'd5;
        start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) start = 1'b0;
        end
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_quo", quo, 32'd0);
        chk("mid_rst_rem", rem, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_dz", 32'(dz), 32'd0);
        rst    = 1'b0;
        start  = 1'b0;
        exp_lq = '0;
        exp_lr = '0;
        cnt_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) cnt_done++;
        end
        chk("mid_rst_no_done", 32'(cnt_done), 32'd0);
        run_op(1'b0, 32'd9, 32'd3, 0, "post_rst");

        for (int t = 0; t < 40; t++) begin
            rs = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 16);
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
            run_op(rs, ra, rb, 0, $sformatf("rand%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
